// File: rtl/seg7_time_display_if.sv
// Time-to-display bus: binary time fields and blank in, multiplexed
// segment/anode/decimal-point drive out.
interface seg7_time_display_if;
  logic [7:0] hours_disp;
  logic [7:0] min_disp;
  logic [7:0] sec_disp;
  logic       blank;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  modport master (output hours_disp, min_disp, sec_disp, blank,
                  input  seg, an, dp);
  modport slave  (input  hours_disp, min_disp, sec_disp, blank,
                  output seg, an, dp);
endinterface

// File: rtl/seg7_time_display.sv
// Six-digit HH.MM.SS multiplexed common-anode 7-segment driver. The time is
// snapshotted once per scan frame so a frame never mixes old and new digits.
module seg7_bcd_field (
  input  logic [7:0]      v,
  output logic [1:0][6:0] code   // [0] = units, [1] = tens
);
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  always_comb begin
    code = {2{7'h3F}};
    // Values above 99 have no two-digit form; both digits show a dash.
    if (v <= 8'd99) begin
      code[1] = seg_of(4'(v / 8'd10));
      code[0] = seg_of(4'(v % 8'd10));
    end
  end
endmodule

module seg7_time_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic               clk,
  input  logic               reset,
  seg7_time_display_if.slave dif
);
  localparam int NUM_FIELDS = 3;   // [0] sec, [1] min, [2] hrs

  logic [CNT_W-1:0]                  div_cnt;
  logic [2:0]                        dig;
  logic [NUM_FIELDS-1:0][7:0]        snap;
  logic [NUM_FIELDS-1:0][7:0]        time_in;
  logic [NUM_FIELDS-1:0][1:0][6:0]   codes;
  logic [2*NUM_FIELDS-1:0][6:0]      digit_codes;
  logic                              wrap;
  logic [6:0]                        seg_nxt, seg_q;
  logic [5:0]                        an_nxt, an_q;
  logic                              dp_nxt, dp_q;

  assign time_in     = {dif.hours_disp, dif.min_disp, dif.sec_disp};
  assign wrap        = (div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign digit_codes = codes;

  generate
    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
      seg7_bcd_field u_field (.v(snap[i]), .code(codes[i]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      dig     <= '0;
      snap    <= '0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) dig <= (dig == 3'd5) ? 3'd0 : dig + 3'd1;
      // Capture on the last cycle of the frame; held for the whole next frame.
      if (wrap && dig == 3'd5) snap <= time_in;
    end
  end

  always_comb begin
    seg_nxt = 7'h7F;
    an_nxt  = 6'h3F;
    dp_nxt  = 1'b1;
    if (dig <= 3'd5) begin
      seg_nxt = digit_codes[dig];
      an_nxt  = ~(6'b1 << dig);
      dp_nxt  = !(dig == 3'd2 || dig == 3'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || dif.blank) begin
      seg_q <= 7'h7F;
      an_q  <= 6'h3F;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
      dp_q  <= dp_nxt;
    end
  end

  assign dif.seg = seg_q;
  assign dif.an  = an_q;
  assign dif.dp  = dp_q;
endmodule

// File: tb/tb_seg7_time_display.sv
// Directed + randomized bench for seg7_time_display against a frame-level
// model: position in the scan is derived from a cycle count since reset.
module tb_seg7_time_display;
  localparam int R     = 4;
  localparam int FRAME = 6 * R;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_time_display_if dif();

  seg7_time_display #(.REFRESH_DIV(R), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset and the displayed snapshot (sec, min, hrs).
  int n = 0;
  int snap [3] = '{0, 0, 0};
  logic [6:0] dtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] exp_seg;
  logic [5:0] exp_an;
  logic       exp_dp;

  function automatic logic [6:0] field_code(input int v, input bit tens);
    if (v > 99) return 7'h3F;
    return dtab[tens ? v / 10 : v % 10];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic tick();
    int d;
    if (reset) begin
      exp_seg = 7'h7F; exp_an = 6'h3F; exp_dp = 1'b1;
      n = 0;
      snap = '{0, 0, 0};
    end else begin
      d = (n / R) % 6;
      exp_seg = dif.blank ? 7'h7F : field_code(snap[d / 2], d % 2 == 1);
      exp_an  = dif.blank ? 6'h3F : 6'h3F ^ (6'd1 << d);
      exp_dp  = dif.blank ? 1'b1  : !(d == 2 || d == 4);
      if (n % FRAME == FRAME - 1)
        snap = '{int'(dif.sec_disp), int'(dif.min_disp), int'(dif.hours_disp)};
      n++;
    end
    @(posedge clk);
    #1;
    chk("seg", {1'b0, dif.seg}, {1'b0, exp_seg});
    chk("an",  {2'b0, dif.an},  {2'b0, exp_an});
    chk("dp",  {7'b0, dif.dp},  {7'b0, exp_dp});
    chk("an_at_most_one_low", 8'($countones(~dif.an) <= 1), 8'd1);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Advance until the next edge is the one at frame position p.
  task automatic tick_until(input int p);
    for (int i = 0; i < FRAME; i++) begin
      if (n % FRAME == p) break;
      tick();
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    dif.hours_disp = 8'(h);
    dif.min_disp   = 8'(m);
    dif.sec_disp   = 8'(s);
  endtask

  initial begin
    reset = 1'b1;
    dif.blank = 1'b0;
    set_time(0, 0, 0);
    ticks(3);

    reset = 1'b0;
    ticks(FRAME);

    ticks(10);
    set_time(23, 59, 7);
    ticks(FRAME - 10 + FRAME);

    tick_until(FRAME - 3);
    dif.sec_disp = 8'd8;
    ticks(FRAME + 4);
    dif.sec_disp = 8'd7;
    tick_until(0);
    ticks(1);
    dif.sec_disp = 8'd8;
    ticks(2 * FRAME);

    set_time(150, 99, 0);
    ticks(2 * FRAME);

    tick_until(5);
    dif.blank = 1'b1;
    ticks(10);
    dif.blank = 1'b0;
    ticks(FRAME + 6);

    set_time(12, 34, 56);
    tick_until(3 * R + 1);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0;
    ticks(2 * FRAME);

    for (int it = 0; it < 25; it++) begin
      set_time($urandom_range(0, 130), $urandom_range(0, 130), $urandom_range(0, 130));
      dif.blank = ($urandom_range(0, 5) == 0);
      reset     = ($urandom_range(0, 15) == 0);
      ticks(1);
      reset = 1'b0;
      ticks($urandom_range(1, 2 * FRAME));
    end
    dif.blank = 1'b0;
    ticks(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
